// File: rtl/pc_gen.sv
// pc_gen: fetch-PC generator with a valid/ready fetch handshake.
//
// Produces the instruction-fetch address. Two redirect sources are merged:
// flush/exception (highest priority) and EX-stage branch. Every fetch carries
// an epoch bit, which flips on each applied redirect, and a sequence number,
// which advances on each accepted request. Together they let IF/ID drop
// wrong-path words.
//
// A request that is offered but not yet accepted is kept stable: pc, epoch,
// seq and fetch_valid do not move. A redirect that arrives during that hold
// is parked in a one-entry pending slot and applied at the accept.
//
// Ports:
//   clk, rst             clock (rising edge) and synchronous active-high reset
//   stall[STALL_W]       per-stage stall; only bit 0 (PC stage) is used
//   flush, flush_pc      flush/exception redirect (highest priority)
//   br_valid, br_pc      EX branch redirect
//   fetch_ready          instruction memory accepts the current request
//   fetch_valid, pc      fetch request and fetch address
//   ce                   memory chip enable; low in the BOOT cycle after reset
//   fetch_epoch          epoch of the current request
//   fetch_seq            sequence number of the current request
//   misalign             one-cycle pulse when a misaligned target is trapped
//
// Build option:
//   PC_GEN_ALIGN_CHK_EN  When defined, an applied target whose low log2(STEP)
//                        bits are non-zero loads TRAP_VEC and pulses misalign.
//                        When undefined, those bits are cleared and misalign
//                        stays 0.

module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(4),
  parameter int              STEP      = 4,
  parameter int              STALL_W   = 6,
  parameter int              SEQ_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [XLEN-1:0]    flush_pc,
  input  logic               br_valid,
  input  logic [XLEN-1:0]    br_pc,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [XLEN-1:0]    pc,
  output logic               ce,
  output logic               fetch_epoch,
  output logic [SEQ_W-1:0]   fetch_seq,
  output logic               misalign
);

`ifdef PC_GEN_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
  // Low bits a legal target must have clear (zero mask when STEP == 1).
  localparam logic [XLEN-1:0] ALIGN_MASK = STEP_V - XLEN'(1);

  typedef enum logic {BOOT, RUN} state_t;

  typedef struct packed {
    logic            v;
    logic            is_flush;
    logic [XLEN-1:0] tgt;
  } redir_t;

  state_t             state_q, state_d;
  redir_t             cur_rd;
  redir_t             pend_q, pend_d;
  logic [XLEN-1:0]    pc_d;
  logic               valid_d, epoch_d, mis_d;
  logic [SEQ_W-1:0]   seq_d;

  // Redirect source applied at this edge (valid only when apply_v is set).
  logic               apply_v;
  logic [XLEN-1:0]    apply_tgt;
  logic               tgt_bad;
  logic [XLEN-1:0]    tgt_fixed;

  // Bits above stall[0] belong to later pipeline stages.
  generate
    if (STALL_W > 1) begin : g_stall_hi
      logic unused_stall_hi;
      assign unused_stall_hi = ^stall[STALL_W-1:1];
    end
  endgenerate

  // Same-cycle redirect merge: flush wins over branch.
  always_comb begin
    cur_rd          = '0;
    cur_rd.v        = flush | br_valid;
    cur_rd.is_flush = flush;
    cur_rd.tgt      = flush ? flush_pc : br_pc;
  end

  // Target conditioning: trap or clear the low bits of a misaligned target.
  always_comb begin
    tgt_bad   = |(apply_tgt & ALIGN_MASK);
    tgt_fixed = apply_tgt & ~ALIGN_MASK;
    if (ALIGN_CHK && tgt_bad) tgt_fixed = TRAP_VEC;
  end

  // BOOT holds ce low for one cycle after reset. The request/redirect logic
  // does not depend on the state, because fetch_valid is already 0 in BOOT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d      = pc;
    valid_d   = fetch_valid;
    epoch_d   = fetch_epoch;
    seq_d     = fetch_seq;
    pend_d    = pend_q;
    apply_v   = 1'b0;
    apply_tgt = pc;
    mis_d     = 1'b0;

    if (!fetch_valid) begin
      // Idle (stalled or BOOT): redirects land directly on pc.
      valid_d = ~stall[0];
      if (pend_q.v) begin
        apply_v   = 1'b1;
        apply_tgt = pend_q.tgt;
      end else if (cur_rd.v) begin
        apply_v   = 1'b1;
        apply_tgt = cur_rd.tgt;
      end
    end else if (fetch_ready) begin
      // Accept: a fresh redirect beats the parked one, else go sequential.
      valid_d = ~stall[0];
      seq_d   = fetch_seq + SEQ_W'(1);
      if (cur_rd.v) begin
        apply_v   = 1'b1;
        apply_tgt = cur_rd.tgt;
      end else if (pend_q.v) begin
        apply_v   = 1'b1;
        apply_tgt = pend_q.tgt;
      end else begin
        pc_d = pc + STEP_V;
      end
    end else begin
      // Held request: everything visible stays put. Park the redirect;
      // a branch must not displace a parked flush.
      if (cur_rd.v && (cur_rd.is_flush || !pend_q.v || !pend_q.is_flush))
        pend_d = cur_rd;
    end

    if (apply_v) begin
      pc_d     = tgt_fixed;
      epoch_d  = ~fetch_epoch;
      pend_d.v = 1'b0;
      mis_d    = ALIGN_CHK & tgt_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc          <= RESET_VEC;
      fetch_valid <= 1'b0;
      fetch_epoch <= 1'b0;
      fetch_seq   <= '0;
      misalign    <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      fetch_valid <= valid_d;
      fetch_epoch <= epoch_d;
      fetch_seq   <= seq_d;
      misalign    <= mis_d;
      pend_q      <= pend_d;
    end
  end

  assign ce = (state_q == RUN);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_valid;
  logic [31:0] br_pc;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic        ce;
  logic        fetch_epoch;
  logic [3:0]  fetch_seq;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_valid(br_valid), .br_pc(br_pc), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .pc(pc), .ce(ce), .fetch_epoch(fetch_epoch),
    .fetch_seq(fetch_seq), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // pc / valid / epoch / seq in one go
  task automatic chk_req(input string tag, input logic [31:0] epc, input logic ev,
                         input logic ee, input logic [3:0] es);
    chk({tag, ".pc"},    pc,                 epc);
    chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, ev});
    chk({tag, ".epoch"}, {31'd0, fetch_epoch}, {31'd0, ee});
    chk({tag, ".seq"},   {28'd0, fetch_seq},   {28'd0, es});
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0;
    br_valid = 1'b0; br_pc = '0; fetch_ready = 1'b1;
    step(); step();
    chk_req("reset", 32'h0, 1'b0, 1'b0, 4'd0);
    chk("reset.ce", {31'd0, ce}, 32'd0);
    chk("reset.mis", {31'd0, misalign}, 32'd0);

    // boot: ce low one cycle, then sequential 0,4,8,C
    rst = 1'b0;
    chk("boot.ce", {31'd0, ce}, 32'd0);
    step();
    chk("run.ce", {31'd0, ce}, 32'd1);
    chk_req("seq0", 32'h0, 1'b1, 1'b0, 4'd0);
    step(); chk_req("seq1", 32'h4, 1'b1, 1'b0, 4'd1);
    step(); chk_req("seq2", 32'h8, 1'b1, 1'b0, 4'd2);

    // held at pc=8 for 3 cycles, branch to 0x40 during the hold
    fetch_ready = 1'b0;
    step(); chk_req("hold1", 32'h8, 1'b1, 1'b0, 4'd2);
    br_valid = 1'b1; br_pc = 32'h40;
    step(); chk_req("hold2", 32'h8, 1'b1, 1'b0, 4'd2);
    br_valid = 1'b0;
    step(); chk_req("hold3", 32'h8, 1'b1, 1'b0, 4'd2);
    fetch_ready = 1'b1;
    step(); chk_req("hold.acc", 32'h40, 1'b1, 1'b1, 4'd3);
    step(); chk_req("after.br", 32'h44, 1'b1, 1'b1, 4'd4);

    // held: br 0x40 then flush 0x100 -> flush wins, single toggle
    fetch_ready = 1'b0;
    step(); chk_req("ovr.h1", 32'h44, 1'b1, 1'b1, 4'd4);
    br_valid = 1'b1; br_pc = 32'h40;
    step(); chk_req("ovr.h2", 32'h44, 1'b1, 1'b1, 4'd4);
    br_valid = 1'b0; flush = 1'b1; flush_pc = 32'h100;
    step(); chk_req("ovr.h3", 32'h44, 1'b1, 1'b1, 4'd4);
    flush = 1'b0; fetch_ready = 1'b1;
    step(); chk_req("ovr.acc", 32'h100, 1'b1, 1'b0, 4'd5);
    step(); chk_req("ovr.next", 32'h104, 1'b1, 1'b0, 4'd6);

    // same-cycle flush + branch: flush target
    flush = 1'b1; flush_pc = 32'h200; br_valid = 1'b1; br_pc = 32'h300;
    step(); chk_req("prio", 32'h200, 1'b1, 1'b1, 4'd7);
    flush = 1'b0; br_valid = 1'b0;
    step(); chk_req("prio.next", 32'h204, 1'b1, 1'b1, 4'd8);

    // stall while idle, flush applies directly
    stall = 6'b000001;
    step(); chk_req("stall.drop", 32'h208, 1'b0, 1'b1, 4'd9);
    flush = 1'b1; flush_pc = 32'h80;
    step(); chk_req("stall.fl", 32'h80, 1'b0, 1'b0, 4'd9);
    flush = 1'b0;
    step(); chk_req("stall.keep", 32'h80, 1'b0, 1'b0, 4'd9);
    stall = 6'b111110;   // upper bits ignored
    step(); chk_req("stall.rel", 32'h80, 1'b1, 1'b0, 4'd9);
    stall = '0;
    step(); chk_req("stall.next", 32'h84, 1'b1, 1'b0, 4'd10);

    // misaligned branch target
    br_valid = 1'b1; br_pc = 32'h42;
    step();
`ifdef PC_GEN_ALIGN_CHK_EN
    chk_req("mis.br", 32'h4, 1'b1, 1'b1, 4'd11);
    chk("mis.pulse", {31'd0, misalign}, 32'd1);
`else
    chk_req("mis.br", 32'h40, 1'b1, 1'b1, 4'd11);
    chk("mis.pulse", {31'd0, misalign}, 32'd0);
`endif
    br_valid = 1'b0;
    step(); chk("mis.clr", {31'd0, misalign}, 32'd0);
    chk("mis.seq", {28'd0, fetch_seq}, 32'd12);

    // sequence counter wrap 12 -> 0
    step(); step(); step(); step();
    chk("seq.wrap", {28'd0, fetch_seq}, 32'd0);

    // pc increment wraps at 2^XLEN
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step(); chk("top.pc", pc, 32'hFFFF_FFFC);
    flush = 1'b0;
    step(); chk("wrap.pc", pc, 32'h0);
    chk("wrap.seq", {28'd0, fetch_seq}, 32'd2);

    // reset during a hold with a parked redirect
    fetch_ready = 1'b0;
    step();
    br_valid = 1'b1; br_pc = 32'h500;
    step();
    br_valid = 1'b0; rst = 1'b1;
    step();
    chk_req("rst.mid", 32'h0, 1'b0, 1'b0, 4'd0);
    chk("rst.ce", {31'd0, ce}, 32'd0);
    rst = 1'b0; fetch_ready = 1'b1;
    step(); chk_req("rst.boot", 32'h0, 1'b1, 1'b0, 4'd0);
    step(); chk_req("rst.seq", 32'h4, 1'b1, 1'b0, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
